// File: rtl/div_pkg.sv
// Shared constants and types for the sequential 16-bit restoring divider.
package div_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

endpackage

// File: rtl/seq_div16_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_div16_if;
   import div_pkg::*;

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );

endinterface

// File: rtl/csel_sub16.sv
// 16-bit carry-select adder and the subtractor built on it (a + ~b + 1).
module csel_add16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   localparam int BLK  = 4;
   localparam int NBLK = 16 / BLK;

   logic [NBLK:0] c;

   assign c[0] = cin;

   // Each 4-bit block precomputes both carry-in cases; the real carry only selects.
   for (genvar i = 0; i < NBLK; i++) begin : g_blk
      logic [BLK:0] s0;
      logic [BLK:0] s1;

      assign s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
      assign s1 = s0 + 5'd1;
      assign sum[i*BLK +: BLK] = c[i] ? s1[BLK-1:0] : s0[BLK-1:0];
      assign c[i+1]            = c[i] ? s1[BLK]     : s0[BLK];
   end

   assign cout = c[NBLK];

endmodule

module csel_sub16 (
   input  logic [15:0] din1,
   input  logic [15:0] din2,
   output logic [15:0] diff,
   output logic        no_borrow
);
   csel_add16 u_add (
      .a    (din1),
      .b    (~din2),
      .cin  (1'b1),
      .sum  (diff),
      .cout (no_borrow)
   );

endmodule

// File: rtl/seq_div16.sv
// Multi-cycle restoring divider: one shift-and-subtract step per clock, signed or unsigned,
// with sign fix-up and divide-by-zero substitution in a final FIX cycle.
module seq_div16
   import div_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   seq_div16_if.slave   bus
);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state, state_next;
   logic             accept;

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] dvd_orig;
   logic             sign_q, sign_r, dz;
   logic [CNT_W-1:0] cnt;

   logic             busy_r, done_r, div_zero_r;
   logic [WIDTH-1:0] quotient_r, remainder_r;

   logic [WIDTH:0]   p_sh;
   logic [WIDTH-1:0] trial_diff;
   logic             trial_nb;
   logic             take;

   logic [WIDTH-1:0] dvd_neg, dvs_neg, q_neg, r_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag_in;
   logic             nb_unused_dvd, nb_unused_dvs, nb_unused_q, nb_unused_r;

   // Trial subtraction of the shifted partial remainder.
   assign p_sh = {p, q[WIDTH-1]};

   csel_sub16 u_trial (
      .din1      (p_sh[WIDTH-1:0]),
      .din2      (dvs_mag),
      .diff      (trial_diff),
      .no_borrow (trial_nb)
   );

   assign take = p_sh[WIDTH] | trial_nb;

   // Negations (0 - x) for operand magnitudes and result sign fix-up.
   csel_sub16 u_neg_dvd (.din1('0), .din2(bus.dividend), .diff(dvd_neg), .no_borrow(nb_unused_dvd));
   csel_sub16 u_neg_dvs (.din1('0), .din2(bus.divisor),  .diff(dvs_neg), .no_borrow(nb_unused_dvs));
   csel_sub16 u_neg_q   (.din1('0), .din2(q),            .diff(q_neg),   .no_borrow(nb_unused_q));
   csel_sub16 u_neg_r   (.din1('0), .din2(p),            .diff(r_neg),   .no_borrow(nb_unused_r));

   assign dvd_mag    = (bus.is_signed && bus.dividend[WIDTH-1]) ? dvd_neg : bus.dividend;
   assign dvs_mag_in = (bus.is_signed && bus.divisor[WIDTH-1])  ? dvs_neg : bus.divisor;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every signal driven here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      unique case (state)
         IDLE: if (bus.start) begin
            accept     = 1'b1;
            state_next = RUN;
         end
         RUN:  if (cnt == LAST_ITER) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p        <= '0;
         q        <= '0;
         dvs_mag  <= '0;
         dvd_orig <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         dz       <= 1'b0;
         cnt      <= '0;
      end else if (accept) begin
         p        <= '0;
         q        <= dvd_mag;
         dvs_mag  <= dvs_mag_in;
         dvd_orig <= bus.dividend;
         sign_q   <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
         sign_r   <= bus.is_signed & bus.dividend[WIDTH-1];
         dz       <= (bus.divisor == '0);
         cnt      <= '0;
      end else if (state == RUN) begin
         p   <= take ? trial_diff : p_sh[WIDTH-1:0];
         q   <= {q[WIDTH-2:0], take};
         cnt <= cnt + 1'b1;
      end
   end

   // Results are only rewritten at FIX, so they hold across a back-to-back accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         div_zero_r  <= 1'b0;
      end else begin
         busy_r <= (state_next == RUN) || (state_next == FIX);
         done_r <= (state_next == DONE);
         if (state == FIX) begin
            if (dz) begin
               quotient_r  <= '1;
               remainder_r <= dvd_orig;
               div_zero_r  <= 1'b1;
            end else begin
               quotient_r  <= sign_q ? q_neg : q;
               remainder_r <= sign_r ? r_neg : p;
               div_zero_r  <= 1'b0;
            end
         end
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_seq_div16.sv
// Scoreboard bench for seq_div16: expected results are modelled at launch and compared on done.
module tb_seq_div16;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sb[$];

   seq_div16_if bus ();

   seq_div16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
      exp_t e;
      int   sa, sbv;
      if (b == 16'h0) begin
         e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
      end else if (s) begin
         sa  = int'($signed(a));
         sbv = int'($signed(b));
         e.q = 16'(sa / sbv); e.r = 16'(sa % sbv); e.dz = 1'b0;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0;
      end
      return e;
   endfunction

   // Called at a falling edge: presents a request for the next rising edge.
   task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
      bus.dividend  = a;
      bus.divisor   = b;
      bus.is_signed = s;
      bus.start     = 1'b1;
      sb.push_back(model(a, b, s));
   endtask

   // Counts rising edges (accept edge = 1) until done is seen; lat = -1 on timeout.
   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done === 1'b1) return;
      end
      lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
      checks++; if (bus.quotient !== 16'h0) begin errors++; $display("FAIL reset_quotient got %h want 0000", bus.quotient); end
      checks++; if (bus.remainder !== 16'h0) begin errors++; $display("FAIL reset_remainder got %h want 0000", bus.remainder); end
      checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", bus.div_zero); end
   endtask

   task automatic test_unsigned();
      exp_t e;
      int   lat;
      launch(16'd1000, 16'd7, 1'b0);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL unsigned_busy_run got %b want 1", bus.busy); end
      wait_done(1, lat);
      checks++; if (lat !== 18) begin errors++; $display("FAIL unsigned_latency got %0d want 18", lat); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL unsigned_busy_done got %b want 0", bus.busy); end
      e = sb.pop_front();
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL unsigned_quotient got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL unsigned_remainder got %h want %h", bus.remainder, e.r); end
      checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL unsigned_div_zero got %b want %b", bus.div_zero, e.dz); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL unsigned_done_pulse got %b want 0", bus.done); end
   endtask

   task automatic test_signed();
      exp_t e;
      int   lat;
      launch(16'hFFF9, 16'h0002, 1'b1);
      wait_done(0, lat);
      e = sb.pop_front();
      checks++; if (lat !== 18) begin errors++; $display("FAIL signed_latency got %0d want 18", lat); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL signed_quotient got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL signed_remainder got %h want %h", bus.remainder, e.r); end
      checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL signed_div_zero got %b want %b", bus.div_zero, e.dz); end
   endtask

   task automatic test_div_zero();
      exp_t e;
      int   lat;
      @(negedge clk);
      launch(16'h1234, 16'h0000, 1'b0);
      wait_done(0, lat);
      e = sb.pop_front();
      checks++; if (lat !== 18) begin errors++; $display("FAIL dz_latency got %0d want 18", lat); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL dz_quotient got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL dz_remainder got %h want %h", bus.remainder, e.r); end
      checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL dz_div_zero got %b want %b", bus.div_zero, e.dz); end
      @(negedge clk);
      launch(16'h8000, 16'hFFFF, 1'b1);
      wait_done(0, lat);
      e = sb.pop_front();
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL ovf_quotient got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL ovf_remainder got %h want %h", bus.remainder, e.r); end
      checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL ovf_div_zero got %b want %b", bus.div_zero, e.dz); end
   endtask

   task automatic test_ignore_start();
      exp_t e;
      int   lat;
      @(negedge clk);
      launch(16'd50000, 16'd123, 1'b0);
      lat = 0;
      repeat (5) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.start = 1'b0;
      end
      bus.dividend = 16'd9; bus.divisor = 16'd4; bus.is_signed = 1'b1;
      bus.start = 1'b1;
      wait_done(lat, lat);
      e = sb.pop_front();
      checks++; if (lat !== 18) begin errors++; $display("FAIL ignore_latency got %0d want 18", lat); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL ignore_quotient got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL ignore_remainder got %h want %h", bus.remainder, e.r); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      exp_t e, first;
      int   lat;
      launch(16'd40000, 16'd300, 1'b0);
      wait_done(0, lat);
      first = sb.pop_front();
      checks++; if (bus.quotient !== first.q) begin errors++; $display("FAIL b2b_first_quotient got %h want %h", bus.quotient, first.q); end
      launch(16'hC000, 16'h0005, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_fall got %b want 0", bus.done); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got %b want 1", bus.busy); end
      checks++; if (bus.remainder !== first.r) begin errors++; $display("FAIL b2b_held_remainder got %h want %h", bus.remainder, first.r); end
      wait_done(1, lat);
      e = sb.pop_front();
      checks++; if (lat !== 18) begin errors++; $display("FAIL b2b_latency got %0d want 18", lat); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL b2b_quotient got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL b2b_remainder got %h want %h", bus.remainder, e.r); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   lat;
      @(negedge clk);
      launch(16'h7FFF, 16'd3, 1'b0);
      repeat (9) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
      end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", bus.busy); end
      #2;
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", bus.done); end
      checks++; if (bus.quotient !== 16'h0) begin errors++; $display("FAIL rstmid_quotient got %h want 0000", bus.quotient); end
      checks++; if (bus.remainder !== 16'h0) begin errors++; $display("FAIL rstmid_remainder got %h want 0000", bus.remainder); end
      checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL rstmid_div_zero got %b want 0", bus.div_zero); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(16'd65535, 16'd255, 1'b0);
      wait_done(0, lat);
      e = sb.pop_front();
      checks++; if (lat !== 18) begin errors++; $display("FAIL rstmid_fresh_latency got %0d want 18", lat); end
      checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL rstmid_fresh_quotient got %h want %h", bus.quotient, e.q); end
      checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL rstmid_fresh_remainder got %h want %h", bus.remainder, e.r); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
